change_dispenser: RTL

Downstream stage of the vending machine controller. It takes the change amount the controller computes after a sale and pays it out as physical coins. It drives one solenoid per coin tube (denominations 5, 2 and 1 units), one coin per pulse, and tracks how many coins are left in each tube. If exact change cannot be paid, it raises an alarm and waits for a tube refill.

---
 rtl/change_dispenser.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as 5/2/1-unit coins, one
// solenoid pulse per coin, tracking the coins left in each tube. Payout is
// greedy (largest coin that fits and is in stock). If no coin fits, the
// block holds the unpaid balance and alarms until a refill arrives.
module change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int TUBE_DEPTH   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_in,
    input  logic             refill,
    output logic             busy,
    output logic             eject_5,
    output logic             eject_2,
    output logic             eject_1,
    output logic [AMT_W-1:0] remaining,
    output logic             done,
    output logic             short_alarm,
    output logic [3:0]       tube_cnt_5,
    output logic [3:0]       tube_cnt_2,
    output logic [3:0]       tube_cnt_1
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       TUBE_FULL  = 4'(TUBE_DEPTH);
    localparam logic [AMT_W-1:0] AMT_5      = AMT_W'(5);
    localparam logic [AMT_W-1:0] AMT_2      = AMT_W'(2);
    localparam logic [AMT_W-1:0] AMT_1      = AMT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_5,
        COIN_2,
        COIN_1
    } coin_t;

    state_t           state, state_nxt;
    coin_t            coin_sel;
    coin_t            pick;
    logic [AMT_W-1:0] pick_val;
    logic [CNT_W-1:0] cnt;
    logic [AMT_W-1:0] rem_q;
    logic [3:0]       t5_q, t2_q, t1_q;
    logic             load_amt;
    logic             take_coin;
    logic             do_refill;

    // Greedy choice: largest in-stock coin not exceeding the balance.
    always_comb begin
        pick     = COIN_NONE;
        pick_val = '0;
        if (rem_q >= AMT_5 && t5_q != 4'd0) begin
            pick     = COIN_5;
            pick_val = AMT_5;
        end else if (rem_q >= AMT_2 && t2_q != 4'd0) begin
            pick     = COIN_2;
            pick_val = AMT_2;
        end else if (rem_q >= AMT_1 && t1_q != 4'd0) begin
            pick     = COIN_1;
            pick_val = AMT_1;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        load_amt  = 1'b0;
        take_coin = 1'b0;
        do_refill = 1'b0;
        case (state)
            S_IDLE: begin
                do_refill = refill;
                if (start) begin
                    load_amt  = 1'b1;
                    state_nxt = (change_in == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == '0) begin
                    state_nxt = S_DONE;
                end else if (pick == COIN_NONE) begin
                    state_nxt = S_FAULT;
                end else begin
                    take_coin = 1'b1;
                    state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt == PULSE_LAST) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) state_nxt = S_SELECT;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (refill) begin
                    do_refill = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so all flops update from pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Phase counter: restarts on every state change, counts within PULSE/GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == S_PULSE || state == S_GAP) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Balance, selected coin and tube stock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            coin_sel <= COIN_NONE;
            t5_q     <= TUBE_FULL;
            t2_q     <= TUBE_FULL;
            t1_q     <= TUBE_FULL;
        end else begin
            if (load_amt) rem_q <= change_in;
            if (do_refill) begin
                t5_q <= TUBE_FULL;
                t2_q <= TUBE_FULL;
                t1_q <= TUBE_FULL;
            end
            if (take_coin) begin
                rem_q    <= rem_q - pick_val;
                coin_sel <= pick;
                case (pick)
                    COIN_5:  t5_q <= t5_q - 4'd1;
                    COIN_2:  t2_q <= t2_q - 4'd1;
                    COIN_1:  t1_q <= t1_q - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign eject_5     = (state == S_PULSE) && (coin_sel == COIN_5);
    assign eject_2     = (state == S_PULSE) && (coin_sel == COIN_2);
    assign eject_1     = (state == S_PULSE) && (coin_sel == COIN_1);
    assign done        = (state == S_DONE);
    assign short_alarm = (state == S_FAULT);
    assign remaining   = rem_q;
    assign tube_cnt_5  = t5_q;
    assign tube_cnt_2  = t2_q;
    assign tube_cnt_1  = t1_q;

endmodule
